// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: T-state control sequencer for register-to-register ALU instructions (optional ALU_SEQ_ZHIGH_WB_EN adds Z high-word writeback)
module alu_op_sequencer #(
  parameter int NREG = 16
) (
  input  logic            Clock,
  input  logic            clear,
  input  logic            start,
  input  logic [4:0]      opcode,
  input  logic [3:0]      ra,
  input  logic [3:0]      rb,
  input  logic [3:0]      rc,
  output logic            busy,
  output logic            done,
  output logic [4:0]      op,
  output logic [NREG-1:0] Rout,
  output logic [NREG-1:0] Rin,
  output logic            Yin,
  output logic            ZHighin,
  output logic            Zlowin,
  output logic            Zlowout,
  output logic            Zhighout
);
  typedef enum logic [2:0] {IDLE, T_Y, T_OP, T_ZLO, T_ZHI} state_t;
  localparam logic [NREG-1:0] ONE = NREG'(1);
  state_t     state_q, state_d;
  logic [4:0] opcode_q;
  logic [3:0] ra_q, rb_q, rc_q;
  logic       in_unary, unary_q, zhi_next;
  assign in_unary = opcode == 5'b10000 || opcode == 5'b10001;
  assign unary_q  = opcode_q == 5'b10000 || opcode_q == 5'b10001;
`ifdef ALU_SEQ_ZHIGH_WB_EN
  assign zhi_next = opcode_q[4:1] == 4'b0111;
`else
  assign zhi_next = 1'b0;
`endif
  // state register plus operand capture on the accepting edge
  always_ff @(posedge Clock) begin
    if (clear) begin
      state_q  <= IDLE;
      opcode_q <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        opcode_q <= opcode;
        ra_q     <= ra;
        rb_q     <= rb;
        rc_q     <= rc;
      end
    end
  end
  // unary ops skip the Y load since their only source goes straight to the ALU
  always_comb
    state_d = state_q == IDLE  ? (start ? (in_unary ? T_OP : T_Y) : IDLE) :
              state_q == T_Y   ? T_OP :
              state_q == T_OP  ? T_ZLO :
              state_q == T_ZLO && zhi_next ? T_ZHI : IDLE;
  // Moore decode of strobes from registered state and operands
  always_comb begin
    busy     = state_q != IDLE;
    Yin      = state_q == T_Y;
    ZHighin  = state_q == T_OP;
    Zlowin   = state_q == T_OP;
    op       = state_q == T_OP ? opcode_q : '0;
    Zlowout  = state_q == T_ZLO;
    Rout     = state_q == T_Y  ? ONE << rb_q :
               state_q == T_OP ? ONE << (unary_q ? rb_q : rc_q) : '0;
`ifdef ALU_SEQ_ZHIGH_WB_EN
    Zhighout = state_q == T_ZHI;
    Rin      = state_q == T_ZLO ? ONE << ra_q :
               state_q == T_ZHI ? ONE << 4'(ra_q + 4'd1) : '0;
    done     = (state_q == T_ZLO && !zhi_next) || state_q == T_ZHI;
`else
    Zhighout = 1'b0;
    Rin      = state_q == T_ZLO ? ONE << ra_q : '0;
    done     = state_q == T_ZLO;
`endif
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and randomized checks of the ALU T-state sequencer against a transfer-level model
module tb_alu_op_sequencer;
  typedef struct packed {
    logic        busy, done;
    logic [4:0]  op;
    logic [15:0] rout, rin;
    logic        yin, zhin, zlin, zlout, zhout;
  } sig_t;
  logic        clk = 1'b0;
  logic        clear, start;
  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        busy, done, Yin, ZHighin, Zlowin, Zlowout, Zhighout;
  logic [4:0]  op;
  logic [15:0] Rout, Rin;
  sig_t        obs;
  sig_t        obs_log [1:4];
  int          tests = 0, fails = 0;
  bit          chk_en = 1'b0;
  always #5 clk = ~clk;
  alu_op_sequencer #(.NREG(16)) dut (
    .Clock(clk), .clear(clear), .start(start), .opcode(opcode),
    .ra(ra), .rb(rb), .rc(rc), .busy(busy), .done(done), .op(op),
    .Rout(Rout), .Rin(Rin), .Yin(Yin), .ZHighin(ZHighin), .Zlowin(Zlowin),
    .Zlowout(Zlowout), .Zhighout(Zhighout)
  );
  assign obs = {busy, done, op, Rout, Rin, Yin, ZHighin, Zlowin, Zlowout, Zhighout};
  // one-hot register strobes must hold in every cycle
  always @(negedge clk) if (chk_en) begin
    tests += 2;
    if ($countones(Rout) > 1) begin fails++; $display("FAIL rout_onehot t=%0t got %h required at most one bit", $time, Rout); end
    if ($countones(Rin) > 1) begin fails++; $display("FAIL rin_onehot t=%0t got %h required at most one bit", $time, Rin); end
  end
  function automatic bit is_un(logic [4:0] o);
    return o == 5'b10000 || o == 5'b10001;
  endfunction
  function automatic int seq_len(logic [4:0] o);
`ifdef ALU_SEQ_ZHIGH_WB_EN
    if (o[4:1] == 4'b0111) return 4;
`endif
    return is_un(o) ? 2 : 3;
  endfunction
  // transfer k of an instruction: 1 load Y, 2 execute, 3 write low word, 4 write high word
  function automatic sig_t expect_step(logic [4:0] o, logic [3:0] a, logic [3:0] b, logic [3:0] c, int k);
    sig_t e = '0;
    int ph = is_un(o) ? k + 1 : k;
    e.busy = 1'b1;
    e.done = k == seq_len(o);
    if (ph == 1) begin e.rout = 16'(1) << b; e.yin = 1'b1; end
    if (ph == 2) begin e.rout = 16'(1) << (is_un(o) ? b : c); e.op = o; e.zhin = 1'b1; e.zlin = 1'b1; end
    if (ph == 3) begin e.rin = 16'(1) << a; e.zlout = 1'b1; end
    if (ph == 4) begin e.rin = 16'(1) << ((a + 1) % 16); e.zhout = 1'b1; end
    return e;
  endfunction
  // mode 0: single start pulse; mode 1: extra start pulse with other operands while busy
  task automatic run_instr(string name, logic [4:0] o, logic [3:0] a, logic [3:0] b, logic [3:0] c, int mode);
    sig_t e;
    int n = seq_len(o);
    @(posedge clk); #1;
    start = 1'b1; opcode = o; ra = a; rb = b; rc = c;
    @(posedge clk); #1;
    start = 1'b0; {opcode, ra, rb, rc} = 17'($urandom);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      obs_log[k] = obs;
      e = expect_step(o, a, b, c, k);
      tests++;
      if (obs !== e) begin fails++; $display("FAIL %s cycle %0d got %h required %h", name, k, obs, e); end
      if (mode == 1 && k == 1) begin start = 1'b1; {opcode, ra, rb, rc} = 17'($urandom); end
      if (mode == 1 && k == 2) start = 1'b0;
    end
    @(negedge clk);
    tests++;
    if (obs !== '0) begin fails++; $display("FAIL %s idle_after got %h required 0", name, obs); end
  endtask
  task automatic test_reset();
    clear = 1'b1; start = 1'b0; opcode = '0; ra = '0; rb = '0; rc = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (obs !== '0) begin fails++; $display("FAIL reset got %h required 0", obs); end
    start = 1'b1; opcode = 5'b00111;
    @(negedge clk);
    tests++;
    if (obs !== '0) begin fails++; $display("FAIL clear_over_start got %h required 0", obs); end
    @(posedge clk); #1;
    clear = 1'b0; start = 1'b0;
    chk_en = 1'b1;
  endtask
  task automatic test_ror();
    sig_t want [1:3];
    want[1] = {1'b1, 1'b0, 5'd0, 16'h0002, 16'h0000, 5'b10000};
    want[2] = {1'b1, 1'b0, 5'b00111, 16'h0004, 16'h0000, 5'b01100};
    want[3] = {1'b1, 1'b1, 5'd0, 16'h0000, 16'h0008, 5'b00010};
    run_instr("ror", 5'b00111, 4'd3, 4'd1, 4'd2, 0);
    for (int k = 1; k <= 3; k++) begin
      tests++;
      if (obs_log[k] !== want[k]) begin fails++; $display("FAIL ror_literal cycle %0d got %h required %h", k, obs_log[k], want[k]); end
    end
  endtask
  task automatic test_not();
    sig_t want [1:2];
    want[1] = {1'b1, 1'b0, 5'b10001, 16'h0020, 16'h0000, 5'b01100};
    want[2] = {1'b1, 1'b1, 5'd0, 16'h0000, 16'h0020, 5'b00010};
    run_instr("not", 5'b10001, 4'd5, 4'd5, 4'd9, 0);
    for (int k = 1; k <= 2; k++) begin
      tests++;
      if (obs_log[k] !== want[k]) begin fails++; $display("FAIL not_literal cycle %0d got %h required %h", k, obs_log[k], want[k]); end
    end
  endtask
  task automatic test_wide();
    sig_t want3, want4;
    run_instr("mul", 5'b01110, 4'd15, 4'd3, 4'd4, 0);
`ifdef ALU_SEQ_ZHIGH_WB_EN
    want3 = {1'b1, 1'b0, 5'd0, 16'h0000, 16'h8000, 5'b00010};
    want4 = {1'b1, 1'b1, 5'd0, 16'h0000, 16'h0001, 5'b00001};
    tests++;
    if (obs_log[4] !== want4) begin fails++; $display("FAIL mul_hi_wrap got %h required %h", obs_log[4], want4); end
`else
    want3 = {1'b1, 1'b1, 5'd0, 16'h0000, 16'h8000, 5'b00010};
    want4 = '0;
    tests++;
    if (obs_log[3].zhout !== want4.zhout) begin fails++; $display("FAIL mul_no_zhi got %b required 0", obs_log[3].zhout); end
`endif
    tests++;
    if (obs_log[3] !== want3) begin fails++; $display("FAIL mul_lo got %h required %h", obs_log[3], want3); end
    run_instr("div", 5'b01111, 4'd7, 4'd0, 4'd14, 0);
  endtask
  task automatic test_clear();
    @(posedge clk); #1;
    start = 1'b1; opcode = 5'b00111; ra = 4'd6; rb = 4'd1; rc = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(negedge clk);
    tests++;
    if (obs !== '0) begin fails++; $display("FAIL clear_abort got %h required 0", obs); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (Rin !== 16'h0 || busy !== 1'b0) begin fails++; $display("FAIL clear_no_rin cycle %0d got rin %h busy %b required 0 0", k, Rin, busy); end
    end
  endtask
  task automatic test_busy();
    run_instr("busy_ignore_bin", 5'b00111, 4'd7, 4'd8, 4'd9, 1);
    run_instr("busy_ignore_un", 5'b10000, 4'd2, 4'd11, 4'd0, 1);
  endtask
  task automatic test_back_to_back();
    sig_t e;
    @(posedge clk); #1;
    start = 1'b1; opcode = 5'b00111; ra = 4'd10; rb = 4'd12; rc = 4'd13;
    @(posedge clk);
    for (int r = 0; r < 2; r++) begin
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        e = expect_step(5'b00111, 4'd10, 4'd12, 4'd13, k);
        tests++;
        if (obs !== e) begin fails++; $display("FAIL b2b rep %0d cycle %0d got %h required %h", r, k, obs, e); end
        if (r == 1 && k == 3) start = 1'b0;
      end
      @(negedge clk);
      tests++;
      if (obs !== '0) begin fails++; $display("FAIL b2b_idle rep %0d got %h required 0", r, obs); end
    end
    @(negedge clk);
    tests++;
    if (obs !== '0) begin fails++; $display("FAIL b2b_stop got %h required 0", obs); end
  endtask
  task automatic test_random();
    logic [4:0] o;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: o = {4'b1000, 1'($urandom_range(0, 1))};
        1: o = {4'b0111, 1'($urandom_range(0, 1))};
        default: o = 5'($urandom);
      endcase
      run_instr("random", o, 4'($urandom), 4'($urandom), 4'($urandom), int'($urandom_range(0, 1)));
    end
  endtask
  initial begin
    test_reset();
    test_ror();
    test_not();
    test_wide();
    test_clear();
    test_busy();
    test_back_to_back();
    test_random();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Control sequencer for register-to-register ALU instructions in the mini CPU datapath. It accepts one decoded ALU instruction per start handshake and walks it through the bus transfer T-states. For each state it drives the one-hot register out/in strobes, Yin, the Z capture enables, the Z readout strobes and the ALU `op` code into `data_path`. It is the hardware that produces the per-cycle control pattern a bench otherwise hand-drives, and sits directly upstream of `data_path`.

## Interface
- `NREG`, 16: number of general registers; width of the one-hot strobe buses.
- `Clock`  in  1  system clock; all state updates on the rising edge.
- `clear`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only in IDLE.
- `opcode`  in  5  ALU operation; copied unchanged to `op`.
- `ra`  in  4  destination register index.
- `rb`  in  4  first source; loaded into Y.
- `rc`  in  4  second source; driven onto the bus in the op cycle.
- `busy`  out  1  high in every non-IDLE state.
- `done`  out  1  high during the final T-state of an instruction.
- `op`  out  5  ALU operation; 0 when not in T_OP.
- `Rout`  out  NREG  one-hot register-to-bus enables.
- `Rin`  out  NREG  one-hot bus-to-register load enables.
- `Yin`, `ZHighin`, `Zlowin`, `Zlowout`, `Zhighout`  out  1 each  datapath strobes.

## Operation
- Operand capture: `opcode`, `ra`, `rb` and `rc` are registered when start is accepted. Input changes during an instruction are ignored.
- Opcode classes:
  - unary: 5'b10000 NEG, 5'b10001 NOT.
  - wide: 5'b01110 MUL, 5'b01111 DIV.
  - binary: every other code, including 5'b00111 ROR.
- FSM states: IDLE, T_Y, T_OP, T_ZLO, T_ZHI.
- IDLE: all outputs 0. If `start`=1, go to T_Y for binary/wide opcodes, or to T_OP for unary opcodes.
- T_Y: `Rout[rb]`=1 and `Yin`=1; next state T_OP.
- T_OP: `Rout[src]`=1, `op`=opcode, `ZHighin`=`Zlowin`=1; next state T_ZLO.
  - src = `rc` for binary/wide, `rb` for unary.
- T_ZLO: `Zlowout`=1 and `Rin[ra]`=1; next state T_ZHI if wide and ZHIGH_WB_EN is defined, otherwise IDLE.
- T_ZHI: `Zhighout`=1 and `Rin[(ra+1) mod 16]`=1; next state IDLE. Index wraps, so ra=15 writes R0.
- All outputs are decoded from registered state and operands only (Moore): no input-to-output combinational path.
- At most one `Rout` bit and at most one `Rin` bit is high in any cycle.
- Aliasing: `ra` equal to `rb` or `rc` is legal. The sources are read in T_Y and T_OP, before the destination write in T_ZLO.
- `start` while busy is ignored, not queued.

## Timing
- Reset: with `clear`=1 at an edge, the next state is IDLE and all outputs are 0 from that edge. This applies in any state, and an instruction in progress is abandoned with no `Rin` pulse issued. `clear` has priority over `start`.
- Latency from the accepting edge (start sampled high in IDLE) to `done`:
  - binary: T_Y, T_OP, T_ZLO, so `done` is high in the 3rd cycle.
  - unary: 2nd cycle.
  - wide with ZHIGH_WB_EN: 4th cycle.
- `busy` rises in the cycle after acceptance and falls in the cycle after `done`.
- Back-to-back: `start` held high through `done` is accepted in the following IDLE cycle. Throughput is therefore one instruction per (T-states + 1) cycles.
- Each strobe is high for exactly one full clock period, edge-aligned. `data_path` registers capture on the rising edge that ends the strobe cycle.

## Configuration
- `ALU_SEQ_ZHIGH_WB_EN` defined:
  - T_ZHI exists; wide opcodes also write the Z high word into R(ra+1 mod 16).
- `ALU_SEQ_ZHIGH_WB_EN` undefined:
  - T_ZHI is not built and `Zhighout` is tied 0.
  - Wide opcodes follow the binary sequence; the high word stays in Z and is discarded.

## Test plan
- ROR, rb=1, rc=2, ra=3, start for one cycle:
  - cycle 1: Rout=0x0002 and Yin.
  - cycle 2: Rout=0x0004, op=5'b00111, ZHighin, Zlowin.
  - cycle 3: Zlowout, Rin=0x0008, done.
  - cycle 4: all outputs 0.
- NOT, rb=5, ra=5:
  - cycle 1: Rout=0x0020, op=5'b10001.
  - cycle 2: Rin=0x0020, done.
  - Yin is never high.
- MUL, ra=15, ZHIGH_WB_EN defined:
  - cycle 3: Rin=0x8000.
  - cycle 4: Zhighout and Rin=0x0001, done.
  - Repeat with the macro undefined: done in cycle 3 and Zhighout stays 0.
- `clear` asserted during T_OP:
  - next cycle IDLE, busy=0, all outputs 0.
  - No Rin pulse ever issued for that instruction.
- Busy and back-to-back behaviour:
  - start pulsed during T_Y with different operands: ignored, and the first instruction completes with its original operands.
  - start held high continuously: a second ROR begins one IDLE cycle after done.
- Every cycle of every scenario: popcount(Rout)≤1 and popcount(Rin)≤1.
